// File: rtl/word_seq_pkg.sv
// Shared widths and FSM state encoding for the word-to-byte sequencer slice.
package word_seq_pkg;

  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;

  // IDLE: nothing loaded; LOW: low byte on eightbits; HIGH: high byte on eightbits.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } seq_state_t;

endpackage

// File: rtl/word_byte_sequencer_if.sv
// Word-side and byte-side valid/ready handshakes of the sequencer.
// master = source/consumer side, slave = sequencer side.
interface word_byte_sequencer_if;
  import word_seq_pkg::*;

  logic [WORD_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;
  logic              byte_valid;
  logic              byte_ready;

  modport master (
    output word_in, word_valid, byte_ready,
    input  word_ready, byte_valid
  );

  modport slave (
    input  word_in, word_valid, byte_ready,
    output word_ready, byte_valid
  );

endinterface

// File: rtl/shiftreg16to8.sv
// Downstream 16-to-8 shift register: load a word, then shift right by a byte.
// eightbits always shows the low byte of the register.
module shiftreg16to8
  import word_seq_pkg::*;
(
  input  logic              clk2,
  input  logic              NReset,
  input  logic [WORD_W-1:0] sixteenbits,
  input  logic              load_enable,
  input  logic              shift_enable,
  output logic [BYTE_W-1:0] eightbits
);

  logic [WORD_W-1:0] sr_q;

  // Load has priority; shift brings the high byte down.
  always_ff @(posedge clk2 or negedge NReset) begin
    if (!NReset) begin
      sr_q <= '0;
    end else if (load_enable) begin
      sr_q <= sixteenbits;
    end else if (shift_enable) begin
      sr_q <= {{BYTE_W{1'b0}}, sr_q[WORD_W-1:BYTE_W]};
    end
  end

  assign eightbits = sr_q[BYTE_W-1:0];

endmodule

// File: rtl/word_fifo.sv
// Synchronous FIFO: registered count, head visible the cycle after a push,
// empty head reads as zero. DEPTH must be a power of 2 and at least 2 so the
// pointers wrap naturally.
module word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                   clk2,
  input  logic                   Reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_next;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_q;
  assign head    = empty ? '0 : mem[rd_ptr];

  // Next occupancy: simultaneous push and pop cancel out.
  always_comb begin
    // NOTE: default first so every path assigns count_next; no latch inferred.
    count_next = count_q;
    case ({do_push, do_pop})
      2'b10:   count_next = count_q + CW'(1);
      2'b01:   count_next = count_q - CW'(1);
      default: count_next = count_q;
    endcase
  end

  // Storage write; data only matters once the count says a slot is live.
  always_ff @(posedge clk2) begin
    // NOTE: storage is deliberately not reset; count/pointers gate its validity.
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy registers with synchronous reset.
  always_ff @(posedge clk2) begin
    // NOTE: non-blocking so every flop samples pre-edge values, order-independent.
    if (Reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_next;
    end
  end

endmodule

// File: rtl/word_byte_sequencer.sv
// Buffers 16-bit words and steers the 16-to-8 shift register so each word
// leaves as two bytes, low byte first, with a byte-level valid/ready.
module word_byte_sequencer
  import word_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk2,
  input  logic                    Reset,
  word_byte_sequencer_if.slave    bus,
  output logic [WORD_W-1:0]       sixteenbits,
  output logic                    load_enable,
  output logic                    shift_enable,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    busy
);

  localparam int CW = $clog2(DEPTH) + 1;

  seq_state_t state_q;
  seq_state_t state_next;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_push;
  logic       full_next;
  logic       word_ready_q;
  logic       byte_valid;

  assign fifo_push = bus.word_valid && word_ready_q;

  word_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk2  (clk2),
    .Reset (Reset),
    .push  (fifo_push),
    .din   (bus.word_in),
    .pop   (load_enable),
    .head  (sixteenbits),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Full after this edge: stays full without a pop, or fills from DEPTH-1.
  assign full_next = (fifo_full && !load_enable) ||
                     ((fifo_count == CW'(DEPTH - 1)) && fifo_push && !load_enable);

  // Registered ready, so the source never sees a combinational path from pop.
  always_ff @(posedge clk2) begin
    if (Reset) word_ready_q <= 1'b0;
    else       word_ready_q <= !full_next;
  end

  // FSM state register.
  always_ff @(posedge clk2) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_next;
  end

  // Next state and shift-register controls; load and shift are exclusive by construction.
  always_comb begin
    state_next   = state_q;
    load_enable  = 1'b0;
    shift_enable = 1'b0;
    byte_valid   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          load_enable = 1'b1;
          state_next  = LOW;
        end
      end
      LOW: begin
        byte_valid = 1'b1;
        if (bus.byte_ready) begin
          shift_enable = 1'b1;
          state_next   = HIGH;
        end
      end
      HIGH: begin
        byte_valid = 1'b1;
        if (bus.byte_ready) begin
          if (!fifo_empty) begin
            load_enable = 1'b1;
            state_next  = LOW;
          end else begin
            state_next  = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.word_ready = word_ready_q;
  assign bus.byte_valid = byte_valid;
  assign busy           = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: doc/word_byte_sequencer.md
# word_byte_sequencer

Upstream control stage for the 16-to-8 shift register. Accepts 16-bit words from the packet/data source over a valid/ready handshake and buffers them in a small FIFO. Drives the shift register's `sixteenbits`, `load_enable` and `shift_enable` so each word leaves as two bytes, low byte first. Provides a byte-level valid/ready handshake to the downstream consumer, aligned with the shift register's `eightbits` output.

## Interface
- `DEPTH`, 4: FIFO depth in words; power of 2, minimum 2.
- `clk2` in 1: sole clock, rising edge.
- `Reset` in 1: reset; one clock, synchronous and active-high.
- `word_in` in 16: word from the upstream source.
- `word_valid` in 1: `word_in` is valid this cycle.
- `word_ready` out 1: the FIFO can accept a word. Registered: equals `!full`, and is 0 while `Reset` is high.
- `sixteenbits` out 16: FIFO head word, to the shift register's `sixteenbits`.
- `load_enable` out 1: to the shift register; load `sixteenbits` at the next edge.
- `shift_enable` out 1: to the shift register; shift right by 8 at the next edge.
- `byte_valid` out 1: the shift register's `eightbits` holds a valid byte this cycle.
- `byte_ready` in 1: the downstream consumer accepts the byte this cycle.
- `fifo_count` out $clog2(DEPTH)+1: number of words currently buffered.
- `busy` out 1: high when state is not IDLE or `fifo_count` is not 0.

## Operation
**FIFO**
- Push occurs when `word_valid && word_ready`.
- Pop occurs when `load_enable` is asserted.
- Push and pop in the same cycle leave the count unchanged.
- A pushed word becomes visible at the head on the next cycle. There is no bypass.
- Pointers wrap modulo DEPTH.

**FSM** (states IDLE, LOW, HIGH)
- **IDLE**
  - If `fifo_count` is not 0: `load_enable`=1, `sixteenbits` = head, pop, go to LOW.
  - Otherwise stay in IDLE.
- **LOW** (low byte is visible on `eightbits`)
  - `byte_valid`=1.
  - On `byte_ready`: `shift_enable`=1, go to HIGH.
  - Otherwise hold: no enables asserted.
- **HIGH** (high byte is visible)
  - `byte_valid`=1.
  - On `byte_ready` with FIFO non-empty: `load_enable`=1, pop, go to LOW. This is the back-to-back case.
  - On `byte_ready` with FIFO empty: go to IDLE.
  - Otherwise hold.

**Output rules**
- `load_enable` and `shift_enable` are never high in the same cycle.
- Both are combinational from state, FIFO-empty and `byte_ready`.
- `sixteenbits` = FIFO head whenever the FIFO is non-empty, and 0 otherwise.

**Boundary conditions**
- Full: `word_ready`=0. A word presented while full is not taken, even if a pop happens in that cycle. The source must hold `word_in`.
- Empty in HIGH: return to IDLE with no bubble beyond the one IDLE cycle.
- `byte_ready` while `byte_valid`=0: ignored.
- Reset mid-word: state goes to IDLE and the FIFO empties. Buffered words and a partially sent word are dropped. The shift register's contents are left stale but are masked by `byte_valid`=0.

## Timing
**Reset values:** state IDLE, `fifo_count`=0, and `word_ready`, `load_enable`, `shift_enable`, `byte_valid`, `busy`, `sixteenbits` all 0. `word_ready` rises in the first cycle after `Reset` falls.

**Latency**
- Word pushed at edge N.
- `load_enable` is high during cycle N+1.
- Low byte has `byte_valid` in cycle N+2.
- High byte has `byte_valid` no earlier than cycle N+3.

**Throughput:** with `byte_ready` tied high and the FIFO never empty, one byte per cycle. `load_enable` pulses every second cycle.

**Stall:** `byte_valid` and the byte value stay stable until accepted.

## Structure
- Package `word_seq_pkg`:
  - `WORD_W`=16, `BYTE_W`=8.
  - Enum `seq_state_t` {IDLE, LOW, HIGH}.
- Sub-module `word_fifo`: synchronous FIFO with the same clock and reset.
  - Parameters `DEPTH` and `WIDTH`.
  - Ports: push/pop, `head`, `full`, `empty`, `count`.
- `word_byte_sequencer` contains the FSM and the glue logic.
- The bench instantiates the sequencer together with `shiftreg16to8`.
  - `NReset` = `!Reset`.
  - `eightbits` is checked against a reference model.

## Test plan
- **Single word:** push 0xA55A, `byte_ready`=1 → bytes 0x5A then 0xA5 on consecutive cycles. `load_enable` high 1 cycle after the push. Then IDLE and `busy`=0.
- **Back-to-back:** push 0x1234, 0x5678, 0x9ABC with `byte_ready`=1 → bytes 34,12,78,56,BC,9A in 6 consecutive cycles, no bubbles.
- **Backpressure:** push 0xBEEF, hold `byte_ready`=0 for 5 cycles in LOW → 0xEF stays valid throughout with no enables asserted. On release, 0xBE follows.
- **Full FIFO:** `byte_ready`=0, push 5 words with DEPTH=4 → `fifo_count` reaches 4 and `word_ready`=0. The 5th word is taken only after the first pop. All 10 bytes arrive in order.
- **Reset mid-word:** `Reset` high while in HIGH with 2 words buffered → next cycle state IDLE, `fifo_count`=0, `byte_valid`=0. A fresh push of 0x00FF yields FF, 00.
- **Wrap-around:** stream 12 words through DEPTH=4 with random `byte_ready` → byte sequence matches the model exactly, and `load_enable`/`shift_enable` are never high together.
